lstm_weight_loader: RTL and testbench

LSTM_WEIGHT_LOADER -- requirements
Module: lstm_weight_loader

---
 rtl/lstm_weight_loader_pkg.sv | 38 +++
 rtl/lstm_csum_acc.sv | 24 ++
 rtl/lstm_weight_loader.sv | 145 ++++++++++++++
 tb/tb_lstm_weight_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_weight_loader_pkg.sv
// Shared definitions for the LSTM parameter-memory loader: FSM states,
// parameter-bank IDs, bank count and error-cause codes.
package lstm_weight_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_LEN  = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4
   } lwl_state_e;

   localparam int unsigned NUM_BANKS = 13;

   localparam logic [3:0] BANK_VO = 4'd0;
   localparam logic [3:0] BANK_UO = 4'd1;
   localparam logic [3:0] BANK_UI = 4'd2;
   localparam logic [3:0] BANK_UF = 4'd3;
   localparam logic [3:0] BANK_UK = 4'd4;
   localparam logic [3:0] BANK_WI = 4'd5;
   localparam logic [3:0] BANK_WO = 4'd6;
   localparam logic [3:0] BANK_WF = 4'd7;
   localparam logic [3:0] BANK_WK = 4'd8;
   localparam logic [3:0] BANK_BI = 4'd9;
   localparam logic [3:0] BANK_BO = 4'd10;
   localparam logic [3:0] BANK_BF = 4'd11;
   localparam logic [3:0] BANK_BK = 4'd12;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_BANK = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;

   // A LEN byte of zero encodes a full 256-byte payload.
   function automatic logic [8:0] len_to_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/lstm_csum_acc.sv
// Running modular-sum accumulator used for the frame checksum.
module lstm_csum_acc #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sum
);

   logic [W-1:0] sum_q;

   // Clear wins over accumulate so a frame end can restart the sum in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       sum_q <= '0;
      else if (clr)  sum_q <= '0;
      else if (en)   sum_q <= sum_q + din;
   end

   assign sum = sum_q;

endmodule

// File: rtl/lstm_weight_loader.sv
// Frame-based loader that writes LSTM weights/biases into parameter banks.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for the BANK byte of a new frame
//  ADDR    | waiting for the start address byte
//  LEN     | waiting for the length byte (0 means 256)
//  DATA    | payload bytes, one write per byte, counter runs down to 1
//  CSUM    | waiting for the checksum byte; frame status is reported next
module lstm_weight_loader
   import lstm_weight_loader_pkg::*;
#(
   parameter int NBANKS = NUM_BANKS,
   parameter int DW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          wr_en,
   output logic [3:0]    wr_bank,
   output logic [DW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code
);

   lwl_state_e    state_q;
   logic          bad_q;
   logic [3:0]    bank_q;
   logic [DW-1:0] addr_q;
   logic [8:0]    cnt_q;

   logic          wr_en_q;
   logic [3:0]    wr_bank_q;
   logic [DW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic [1:0]    err_code_q;

   logic          accept;
   logic          csum_clr;
   logic [DW-1:0] csum_sum;
   logic [DW-1:0] csum_total_d;
   logic          bank_bad_d;

   assign s_ready      = cen && !rst;
   assign accept       = s_valid && s_ready;
   assign csum_clr     = accept && (state_q == ST_CSUM);
   assign csum_total_d = csum_sum + s_data;
   assign bank_bad_d   = (s_data >= DW'(NBANKS));

   lstm_csum_acc #(.W(DW)) u_csum (
      .clk (clk),
      .rst (rst),
      .clr (csum_clr),
      .en  (accept),
      .din (s_data),
      .sum (csum_sum)
   );

   // Frame FSM with registered write port and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bad_q      <= 1'b0;
         bank_q     <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_bank_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_IDLE: begin
                  bad_q   <= bank_bad_d;
                  bank_q  <= s_data[3:0];
                  busy_q  <= 1'b1;
                  state_q <= ST_ADDR;
               end
               ST_ADDR: begin
                  addr_q  <= s_data;
                  state_q <= ST_LEN;
               end
               ST_LEN: begin
                  cnt_q   <= len_to_count(s_data[7:0]);
                  state_q <= ST_DATA;
               end
               ST_DATA: begin
                  // A bad-bank frame is consumed silently; the write bus stays quiet.
                  if (!bad_q) begin
                     wr_en_q   <= 1'b1;
                     wr_bank_q <= bank_q;
                     wr_addr_q <= addr_q;
                     wr_data_q <= s_data;
                  end
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 9'd1;
                  if (cnt_q == 9'd1) state_q <= ST_CSUM;
               end
               ST_CSUM: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                  if (bad_q) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_BANK;
                  end else if (csum_total_d != '0) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_CSUM;
                  end else begin
                     err_code_q <= ERR_NONE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_bank  = wr_bank_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_lstm_weight_loader.sv
// Directed self-checking bench for lstm_weight_loader.
module tb_lstm_weight_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       wr_en;
   logic [3:0] wr_bank;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] bank;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t wq[$];
   int  done_cnt = 0;
   int  err_cnt  = 0;
   int  both_cnt = 0;

   logic [7:0] frm[$];

   lstm_weight_loader dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .wr_en    (wr_en),
      .wr_bank  (wr_bank),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   // Log every write strobe and status pulse, sampled away from the active edge.
   always @(negedge clk) begin
      if (wr_en) wq.push_back('{bank: wr_bank, addr: wr_addr, data: wr_data});
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      s_data  = b;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_frm();
      foreach (frm[i]) send_byte(frm[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1; cen = 1'b1; s_valid = 1'b0; s_data = 8'h00;
      tick(3);
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      n_checks++;
      if ({wr_en, busy, done, err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {wr_en, busy, done, err});
      end
      n_checks++;
      if ({wr_bank, wr_addr, wr_data, err_code} !== 22'd0) begin
         n_fail++; $display("FAIL reset_bus: got %h expected 0", {wr_bank, wr_addr, wr_data, err_code});
      end
      rst = 1'b0;
      tick(1);
      n_checks++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", s_ready); end
   endtask

   task automatic test_basic();
      int wb = wq.size();
      int db = done_cnt;
      int eb = err_cnt;
      logic [7:0] ea [3] = '{8'h10, 8'h11, 8'h12};
      logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
      send_byte(8'h02);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
      frm = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h85};
      send_frm();
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: got %b expected 1", done); end
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 3) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 3", wq.size() - wb); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wq[wb+i].bank !== 4'd2 || wq[wb+i].addr !== ea[i] || wq[wb+i].data !== ed[i]) begin
               n_fail++;
               $display("FAIL basic_wr%0d: got b%0d a%h d%h expected b2 a%h d%h",
                        i, wq[wb+i].bank, wq[wb+i].addr, wq[wb+i].data, ea[i], ed[i]);
            end
         end
      end
      n_checks++;
      if (done_cnt - db !== 1 || err_cnt - eb !== 0) begin
         n_fail++; $display("FAIL basic_status: got done %0d err %0d expected 1 0", done_cnt - db, err_cnt - eb);
      end
      n_checks++;
      if (err_code !== 2'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_code_busy: got code %0d busy %b expected 0 0", err_code, busy);
      end
   endtask

   task automatic test_csum_err();
      int wb = wq.size();
      int db = done_cnt;
      int bb = both_cnt;
      frm = '{8'h02, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h86};
      send_frm();
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 3) begin n_fail++; $display("FAIL csum_wr_count: got %0d expected 3", wq.size() - wb); end
      n_checks++;
      if (done_cnt - db !== 1 || both_cnt - bb !== 1) begin
         n_fail++; $display("FAIL csum_pulses: got done %0d both %0d expected 1 1", done_cnt - db, both_cnt - bb);
      end
      n_checks++;
      if (err_code !== 2'd2) begin n_fail++; $display("FAIL csum_code: got %0d expected 2", err_code); end
   endtask

   task automatic test_bad_bank();
      int wb = wq.size();
      int db = done_cnt;
      int bb = both_cnt;
      frm = '{8'h0D, 8'h00, 8'h01, 8'hAA, 8'h48};
      send_frm();
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 0) begin n_fail++; $display("FAIL badbank_wr_count: got %0d expected 0", wq.size() - wb); end
      n_checks++;
      if (done_cnt - db !== 1 || both_cnt - bb !== 1) begin
         n_fail++; $display("FAIL badbank_pulses: got done %0d both %0d expected 1 1", done_cnt - db, both_cnt - bb);
      end
      n_checks++;
      if (err_code !== 2'd1) begin n_fail++; $display("FAIL badbank_code: got %0d expected 1", err_code); end
   endtask

   // Checksum byte F4 makes 05+FE+03+01+02+03+F4 sum to zero modulo 256.
   task automatic test_wrap();
      int wb = wq.size();
      int eb = err_cnt;
      logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
      frm = '{8'h05, 8'hFE, 8'h03, 8'h01};
      send_frm();
      n_checks++;
      if (err_code !== 2'd1) begin n_fail++; $display("FAIL wrap_code_hold: got %0d expected 1", err_code); end
      frm = '{8'h02, 8'h03, 8'hF4};
      send_frm();
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 3) begin n_fail++; $display("FAIL wrap_wr_count: got %0d expected 3", wq.size() - wb); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wq[wb+i].bank !== 4'd5 || wq[wb+i].addr !== ea[i] || wq[wb+i].data !== 8'(i + 1)) begin
               n_fail++;
               $display("FAIL wrap_wr%0d: got b%0d a%h d%h expected b5 a%h d%h",
                        i, wq[wb+i].bank, wq[wb+i].addr, wq[wb+i].data, ea[i], i + 1);
            end
         end
      end
      n_checks++;
      if (err_cnt - eb !== 0 || err_code !== 2'd0) begin
         n_fail++; $display("FAIL wrap_status: got err %0d code %0d expected 0 0", err_cnt - eb, err_code);
      end
   endtask

   task automatic test_len256();
      int wb = wq.size();
      int db = done_cnt;
      int eb = err_cnt;
      int bad = 0;
      logic [7:0] sum;
      logic [7:0] d;
      frm = '{8'h09, 8'h00, 8'h00};
      send_frm();
      sum = 8'h09;
      for (int i = 0; i < 256; i++) begin
         d = 8'(i) ^ 8'h5A;
         sum = sum + d;
         send_byte(d);
      end
      n_checks++;
      if (done_cnt - db !== 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL len256_early_done: got done %0d busy %b expected 0 1", done_cnt - db, busy);
      end
      send_byte(8'h00 - sum);
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 256) begin
         n_fail++; $display("FAIL len256_wr_count: got %0d expected 256", wq.size() - wb);
      end else begin
         for (int i = 0; i < 256; i++) begin
            if (wq[wb+i].bank !== 4'd9 || wq[wb+i].addr !== 8'(i) || wq[wb+i].data !== (8'(i) ^ 8'h5A)) bad++;
         end
         n_checks++;
         if (bad !== 0) begin n_fail++; $display("FAIL len256_contents: got %0d bad writes expected 0", bad); end
      end
      n_checks++;
      if (done_cnt - db !== 1 || err_cnt - eb !== 0) begin
         n_fail++; $display("FAIL len256_status: got done %0d err %0d expected 1 0", done_cnt - db, err_cnt - eb);
      end
   endtask

   // Frame 03 40 04 10 20 30 40 19 sums to zero; a 5-cycle cen stall sits mid-payload.
   task automatic test_stress();
      int wb = wq.size();
      int db = done_cnt;
      int eb = err_cnt;
      int rdy_hi = 0;
      frm = '{8'h03, 8'h40, 8'h04, 8'h10, 8'h20};
      send_frm();
      cen = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (s_ready !== 1'b0) rdy_hi++;
      end
      n_checks++;
      if (rdy_hi !== 0) begin n_fail++; $display("FAIL stall_ready: got %0d high cycles expected 0", rdy_hi); end
      n_checks++;
      if (wq.size() - wb !== 2) begin n_fail++; $display("FAIL stall_writes: got %0d expected 2", wq.size() - wb); end
      s_valid = 1'b0; cen = 1'b1;
      frm = '{8'h30, 8'h40, 8'h19};
      send_frm();
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 4) begin n_fail++; $display("FAIL stall_wr_count: got %0d expected 4", wq.size() - wb); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wq[wb+i].bank !== 4'd3 || wq[wb+i].addr !== 8'(8'h40 + i) || wq[wb+i].data !== 8'(16 * (i + 1))) begin
               n_fail++;
               $display("FAIL stall_wr%0d: got b%0d a%h d%h expected b3 a%h d%h",
                        i, wq[wb+i].bank, wq[wb+i].addr, wq[wb+i].data, 8'h40 + i, 16 * (i + 1));
            end
         end
      end
      n_checks++;
      if (done_cnt - db !== 1 || err_cnt - eb !== 0) begin
         n_fail++; $display("FAIL stall_status: got done %0d err %0d expected 1 0", done_cnt - db, err_cnt - eb);
      end

      // Abort a bank-7 frame after its second data byte, then run a fresh frame.
      db = done_cnt;
      eb = err_cnt;
      frm = '{8'h07, 8'h80, 8'h03, 8'h01, 8'h02};
      send_frm();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, wr_en, s_ready} !== 3'b000) begin
         n_fail++; $display("FAIL abort_reset_outputs: got %b expected 000", {busy, wr_en, s_ready});
      end
      tick(1);
      rst = 1'b0;
      tick(2);
      wb = wq.size();
      // 01 20 02 55 66 22 sums to zero.
      frm = '{8'h01, 8'h20, 8'h02, 8'h55, 8'h66, 8'h22};
      send_frm();
      tick(2);
      n_checks++;
      if (wq.size() - wb !== 2) begin n_fail++; $display("FAIL abort_wr_count: got %0d expected 2", wq.size() - wb); end
      else begin
         n_checks++;
         if (wq[wb].bank !== 4'd1 || wq[wb].addr !== 8'h20 || wq[wb].data !== 8'h55 ||
             wq[wb+1].bank !== 4'd1 || wq[wb+1].addr !== 8'h21 || wq[wb+1].data !== 8'h66) begin
            n_fail++;
            $display("FAIL abort_new_frame: got b%0d a%h d%h / b%0d a%h d%h expected b1 a20 d55 / b1 a21 d66",
                     wq[wb].bank, wq[wb].addr, wq[wb].data, wq[wb+1].bank, wq[wb+1].addr, wq[wb+1].data);
         end
      end
      n_checks++;
      if (done_cnt - db !== 1 || err_cnt - eb !== 0 || err_code !== 2'd0) begin
         n_fail++;
         $display("FAIL abort_status: got done %0d err %0d code %0d expected 1 0 0",
                  done_cnt - db, err_cnt - eb, err_code);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_csum_err();
      test_bad_bank();
      test_wrap();
      test_len256();
      test_stress();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
